// File: rtl/cache_block_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_block_ctrl_if
// Bundles every non-clock/reset signal of cache_block_ctrl.
//   master : the environment (CPU side, tag/data arrays, memory) drives
//            req/hit/dirty/mem_ready and observes the controller outputs.
//   slave  : the controller itself.
// Signals:
//   req, hit, dirty, mem_ready             - inputs to the controller
//   mem_rd, mem_wr, victim_rd, cache_write - per-word transfer strobes
//   line_valid_set                         - validate line on last fill word
//   offset [OFFSET_W]                      - word offset within the block
//   cache_hit, done, busy                  - access status
//   hit_cnt, miss_cnt [CNT_W]              - saturating statistics
// -----------------------------------------------------------------------------
interface cache_block_ctrl_if #(
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
);
  logic                req;
  logic                hit;
  logic                dirty;
  logic                mem_ready;
  logic                mem_rd;
  logic                mem_wr;
  logic                victim_rd;
  logic                cache_write;
  logic                line_valid_set;
  logic [OFFSET_W-1:0] offset;
  logic                cache_hit;
  logic                done;
  logic                busy;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;

  modport master (
    output req, hit, dirty, mem_ready,
    input  mem_rd, mem_wr, victim_rd, cache_write, line_valid_set,
           offset, cache_hit, done, busy, hit_cnt, miss_cnt
  );

  modport slave (
    input  req, hit, dirty, mem_ready,
    output mem_rd, mem_wr, victim_rd, cache_write, line_valid_set,
           offset, cache_hit, done, busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_block_ctrl.sv
// -----------------------------------------------------------------------------
// cache_block_ctrl
// Direct-mapped cache line controller. On a miss it optionally writes the
// dirty victim block back to memory word by word, then refills the block
// word by word, each word gated by the memory handshake (mem_ready).
// Keeps saturating hit/miss counters.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - cache_block_ctrl_if.slave (request, tag result, memory handshake,
//          array strobes, status and statistics)
// Parameters:
//   OFFSET_W   - word-offset width, block = 2**OFFSET_W words (1..4)
//   WRITE_BACK - 1: write back dirty victim before refill; 0: dirty ignored
//   CNT_W      - statistics counter width
// -----------------------------------------------------------------------------
module cache_block_ctrl #(
  parameter int OFFSET_W   = 2,
  parameter bit WRITE_BACK = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_block_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  logic [2:0]          state_q,    state_d;
  logic [OFFSET_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0]    hit_cnt_q,  hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic last_word;
  assign last_word = (cnt_q == LAST_WORD);

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) state_d = S_LOOKUP;
      end

      S_LOOKUP: begin
        cnt_d = '0;
        if (bus.hit) begin
          state_d = S_DONE;
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d = (WRITE_BACK && bus.dirty) ? S_WB : S_FILL;
        end
      end

      S_WB: begin
        if (bus.mem_ready) begin
          // Increment wraps to 0 on the last word, ready for the fill.
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (bus.mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Outputs decode the registered state, so an asynchronous reset clears
  // them immediately and an abandoned transfer issues no further strobes.
  always_comb begin
    bus.busy           = (state_q != S_IDLE);
    bus.mem_wr         = (state_q == S_WB);
    bus.victim_rd      = (state_q == S_WB);
    bus.mem_rd         = (state_q == S_FILL);
    bus.cache_write    = (state_q == S_FILL) && bus.mem_ready;
    bus.line_valid_set = (state_q == S_FILL) && bus.mem_ready && last_word;
    bus.cache_hit      = (state_q == S_LOOKUP) && bus.hit;
    bus.done           = (state_q == S_DONE);
    bus.offset         = cnt_q;
    bus.hit_cnt        = hit_cnt_q;
    bus.miss_cnt       = miss_cnt_q;
  end

endmodule

// File: tb/tb_cache_block_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_block_ctrl
// Three controller instances sharing clk/rst:
//   0: OFFSET_W=2, WRITE_BACK=1, CNT_W=16
//   1: OFFSET_W=2, WRITE_BACK=0, CNT_W=16
//   2: OFFSET_W=2, WRITE_BACK=1, CNT_W=2
// Each access pushes its expected beats (write-back word, fill word, hit,
// done) to a scoreboard queue; beats observed on the DUT are popped and
// compared in order. Completion cycle and counters come from a small model.
// -----------------------------------------------------------------------------
module tb_cache_block_ctrl;

  localparam logic [2:0] K_WB   = 3'd1;
  localparam logic [2:0] K_FILL = 3'd2;
  localparam logic [2:0] K_HIT  = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;

  localparam bit WB_P   [3] = '{1'b1, 1'b0, 1'b1};
  localparam int CNT_MX [3] = '{65535, 65535, 3};

  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] off;
    logic       lvs;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] req_v   = '0;
  logic [2:0] hit_v   = '0;
  logic [2:0] dirty_v = '0;
  logic [2:0] rdy_v   = '0;

  logic [2:0] mem_rd_v, mem_wr_v, victim_rd_v, cache_write_v, lvs_v;
  logic [2:0] cache_hit_v, done_v, busy_v;
  logic [1:0]  off_v   [3];
  logic [15:0] hcnt_v  [3];
  logic [15:0] mcnt_v  [3];

  cache_block_ctrl_if #(.OFFSET_W(2), .CNT_W(16)) if_a ();
  cache_block_ctrl_if #(.OFFSET_W(2), .CNT_W(16)) if_b ();
  cache_block_ctrl_if #(.OFFSET_W(2), .CNT_W(2))  if_c ();

  cache_block_ctrl #(.OFFSET_W(2), .WRITE_BACK(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  cache_block_ctrl #(.OFFSET_W(2), .WRITE_BACK(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  cache_block_ctrl #(.OFFSET_W(2), .WRITE_BACK(1'b1), .CNT_W(2))  dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.req = req_v[0]; assign if_a.hit = hit_v[0];
  assign if_a.dirty = dirty_v[0]; assign if_a.mem_ready = rdy_v[0];
  assign if_b.req = req_v[1]; assign if_b.hit = hit_v[1];
  assign if_b.dirty = dirty_v[1]; assign if_b.mem_ready = rdy_v[1];
  assign if_c.req = req_v[2]; assign if_c.hit = hit_v[2];
  assign if_c.dirty = dirty_v[2]; assign if_c.mem_ready = rdy_v[2];

  assign mem_rd_v      = {if_c.mem_rd, if_b.mem_rd, if_a.mem_rd};
  assign mem_wr_v      = {if_c.mem_wr, if_b.mem_wr, if_a.mem_wr};
  assign victim_rd_v   = {if_c.victim_rd, if_b.victim_rd, if_a.victim_rd};
  assign cache_write_v = {if_c.cache_write, if_b.cache_write, if_a.cache_write};
  assign lvs_v         = {if_c.line_valid_set, if_b.line_valid_set, if_a.line_valid_set};
  assign cache_hit_v   = {if_c.cache_hit, if_b.cache_hit, if_a.cache_hit};
  assign done_v        = {if_c.done, if_b.done, if_a.done};
  assign busy_v        = {if_c.busy, if_b.busy, if_a.busy};
  assign off_v[0] = if_a.offset;
  assign off_v[1] = if_b.offset;
  assign off_v[2] = if_c.offset;
  assign hcnt_v[0] = if_a.hit_cnt;
  assign hcnt_v[1] = if_b.hit_cnt;
  assign hcnt_v[2] = {14'd0, if_c.hit_cnt};
  assign mcnt_v[0] = if_a.miss_cnt;
  assign mcnt_v[1] = if_b.miss_cnt;
  assign mcnt_v[2] = {14'd0, if_c.miss_cnt};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hit  [3] = '{0, 0, 0};
  int exp_miss [3] = '{0, 0, 0};
  beat_t sb [$];

  // mode 0: memory always ready; mode 1: ready only on even cycles.
  function automatic bit ready_at(input int mode, input int k);
    return (mode == 0) ? 1'b1 : ((k % 2) == 0);
  endfunction

  function automatic bit outputs_quiet(input int d);
    return {mem_rd_v[d], mem_wr_v[d], victim_rd_v[d], cache_write_v[d],
            lvs_v[d], cache_hit_v[d], done_v[d], busy_v[d]} == 8'd0
           && off_v[d] == 2'd0;
  endfunction

  // One access on DUT d. Cycle k=1 is the IDLE cycle with req high.
  // abort_k > 0 asserts rst shortly after the start of that cycle.
  task automatic run_access(input int d, input bit hit, input bit dirty,
                            input int mode, input bit hold_req, input int abort_k);
    int    need, k_exp, done_k, kk;
    bit    bad, ev, aborted, wb_phase;
    beat_t obs, exp_b;
    sb.delete();
    wb_phase = !hit && WB_P[d] && dirty;
    if (hit) begin
      sb.push_back('{kind: K_HIT, off: 2'd0, lvs: 1'b0});
      k_exp = 3;
    end else begin
      if (wb_phase)
        for (int i = 0; i < 4; i++) sb.push_back('{kind: K_WB, off: 2'(i), lvs: 1'b0});
      for (int i = 0; i < 4; i++) sb.push_back('{kind: K_FILL, off: 2'(i), lvs: (i == 3)});
      need = wb_phase ? 8 : 4;
      kk   = 3;
      while (need > 0) begin
        if (ready_at(mode, kk)) need--;
        kk++;
      end
      k_exp = kk;
    end
    sb.push_back('{kind: K_DONE, off: 2'd0, lvs: 1'b0});

    done_k = 0; bad = 1'b0; aborted = 1'b0;
    for (int k = 1; k <= 60 && done_k == 0 && !aborted; k++) begin
      @(posedge clk); #1;
      req_v[d]   = (k == 1) || hold_req;
      hit_v[d]   = hit;
      dirty_v[d] = dirty;
      rdy_v[d]   = ready_at(mode, k);
      if (k == abort_k) begin
        n_checks++;
        if (busy_v[d] !== 1'b1)
          $display("FAIL busy_before_rst dut=%0d got=%b exp=1", d, busy_v[d]);
        if (busy_v[d] !== 1'b1) n_fail++;
        #1 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (!outputs_quiet(j) || hcnt_v[j] !== 16'd0 || mcnt_v[j] !== 16'd0) begin
            n_fail++;
            $display("FAIL async_rst dut=%0d busy=%b off=%0d hcnt=%0d mcnt=%0d exp all 0",
                     j, busy_v[j], off_v[j], hcnt_v[j], mcnt_v[j]);
          end
          exp_hit[j]  = 0;
          exp_miss[j] = 0;
        end
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        if (mem_wr_v[d] !== victim_rd_v[d]) bad = 1'b1;
        if (lvs_v[d] && !cache_write_v[d]) bad = 1'b1;
        if (cache_write_v[d] && !mem_rd_v[d]) bad = 1'b1;
        if (hit && (mem_rd_v[d] || mem_wr_v[d])) bad = 1'b1;
        ev = 1'b1;
        if (mem_wr_v[d] && rdy_v[d])  obs = '{kind: K_WB,   off: off_v[d], lvs: lvs_v[d]};
        else if (cache_write_v[d])    obs = '{kind: K_FILL, off: off_v[d], lvs: lvs_v[d]};
        else if (cache_hit_v[d])      obs = '{kind: K_HIT,  off: off_v[d], lvs: lvs_v[d]};
        else if (done_v[d])           obs = '{kind: K_DONE, off: off_v[d], lvs: lvs_v[d]};
        else                          ev  = 1'b0;
        if (ev) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat dut=%0d k=%0d got kind=%0d off=%0d lvs=%b exp none",
                     d, k, obs.kind, obs.off, obs.lvs);
          end else begin
            exp_b = sb.pop_front();
            if (obs !== exp_b) begin
              n_fail++;
              $display("FAIL beat dut=%0d k=%0d got kind=%0d off=%0d lvs=%b exp kind=%0d off=%0d lvs=%b",
                       d, k, obs.kind, obs.off, obs.lvs, exp_b.kind, exp_b.off, exp_b.lvs);
            end
          end
        end
        if (done_v[d] === 1'b1) done_k = k;
      end
    end

    if (aborted) begin
      // Hold reset a few cycles: the abandoned line must never be validated.
      req_v[d] = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (!outputs_quiet(d)) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL quiet_in_rst dut=%0d got activity exp none", d);
      end
      #2 rst = 1'b0;
      sb.delete();
    end else begin
      n_checks++;
      if (done_k != k_exp) begin
        n_fail++;
        $display("FAIL done_cycle dut=%0d got=%0d exp=%0d (0 = timeout)", d, done_k, k_exp);
      end
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL missing_beats dut=%0d got=%0d left exp=0", d, sb.size());
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL strobe_protocol dut=%0d got violation exp none", d);
      end
      if (hit) exp_hit[d]  = (exp_hit[d]  < CNT_MX[d]) ? exp_hit[d] + 1  : exp_hit[d];
      else     exp_miss[d] = (exp_miss[d] < CNT_MX[d]) ? exp_miss[d] + 1 : exp_miss[d];
      @(posedge clk); #1;
      req_v[d] = 1'b0; hit_v[d] = 1'b0; dirty_v[d] = 1'b0; rdy_v[d] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_v[d] !== 1'b0 || hcnt_v[d] !== 16'(exp_hit[d]) || mcnt_v[d] !== 16'(exp_miss[d])) begin
        n_fail++;
        $display("FAIL idle_counters dut=%0d got busy=%b hit=%0d miss=%0d exp busy=0 hit=%0d miss=%0d",
                 d, busy_v[d], hcnt_v[d], mcnt_v[d], exp_hit[d], exp_miss[d]);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (!outputs_quiet(j) || hcnt_v[j] !== 16'd0 || mcnt_v[j] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d busy=%b off=%0d hcnt=%0d mcnt=%0d exp all 0",
                 j, busy_v[j], off_v[j], hcnt_v[j], mcnt_v[j]);
      end
    end
    @(negedge clk); rst = 1'b0;
    // Pulse reset in the middle of LOOKUP on instance 0.
    run_access(0, 1'b0, 1'b1, 0, 1'b0, 2);
  endtask

  task automatic test_hit();
    run_access(0, 1'b1, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_clean_miss();
    run_access(0, 1'b0, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_dirty_miss_stall();
    run_access(0, 1'b0, 1'b1, 1, 1'b0, 0);
  endtask

  task automatic test_no_write_back();
    run_access(1, 1'b0, 1'b1, 1, 1'b0, 0);
  endtask

  task automatic test_back_to_back_saturate();
    for (int i = 0; i < 5; i++) run_access(2, 1'b1, 1'b0, 0, 1'b0, 0);
    run_access(2, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_fill();
    // Cycles 3,4,5 are fill offsets 0,1,2; reset lands during offset 2
    // with req held high, which the controller must ignore.
    run_access(2, 1'b0, 1'b0, 0, 1'b1, 5);
    run_access(2, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss_stall();
    test_no_write_back();
    test_back_to_back_saturate();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_block_ctrl.md
Name: cache_block_ctrl

Overview:
- Parametrised cache line controller; the next generation of the team's 4-word direct-mapped refill FSM.
- Sits between the CPU-side request, the cache tag/data arrays and the main-memory word interface.
- Generalises block size via OFFSET_W and adds optional dirty-victim write-back before refill.
- Adds a per-word memory handshake and saturating hit/miss statistics counters.

Parameters:
- OFFSET_W, 2, word-offset width; block holds 2**OFFSET_W words (legal 1..4).
- WRITE_BACK, 1, 1 = write back dirty victim before refill; 0 = write-through, dirty ignored.
- CNT_W, 16, width of hit/miss statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  1  CPU access request; sampled only in IDLE
- hit  in  1  tag compare result for current address; valid in LOOKUP
- dirty  in  1  victim line dirty bit; valid in LOOKUP
- mem_ready  in  1  memory has accepted (write) or supplied (read) the current word this cycle
- mem_rd  out  1  memory read request for word at offset
- mem_wr  out  1  memory write request for victim word at offset
- victim_rd  out  1  cache array read enable for victim word at offset
- cache_write  out  1  cache data write enable for fill word at offset
- line_valid_set  out  1  set valid bit, load tag, clear dirty; pulses with the last fill word
- offset  out  OFFSET_W  current word offset within block
- cache_hit  out  1  one-cycle pulse on a hit
- done  out  1  one-cycle pulse when the access completes
- busy  out  1  high in every state except IDLE
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (async, any state): state=IDLE, word counter=0, hit_cnt=miss_cnt=0; all 1-bit outputs 0; offset=0.
- States: IDLE, LOOKUP, WB, FILL, DONE. Registered state. Outputs decode state and counter combinationally; cache_write and line_valid_set are additionally qualified by mem_ready.
- IDLE: busy=0. If req=1, go to LOOKUP next cycle. req is ignored in all other states; there is no queueing.
- LOOKUP (1 cycle):
  - hit=1: cache_hit=1; hit_cnt+1; next state DONE.
  - hit=0: miss_cnt+1. If WRITE_BACK=1 and dirty=1, next state WB; otherwise next state FILL. Word counter=0.
- WB: mem_wr=1, victim_rd=1, offset=counter.
  - mem_ready=0: hold; counter and outputs unchanged.
  - mem_ready=1: counter+1.
  - mem_ready=1 on the last word (counter=2**OFFSET_W-1): counter wraps to 0; next state FILL.
- FILL: mem_rd=1, offset=counter.
  - mem_ready=1: cache_write=1 in the same cycle; counter+1.
  - Last word with mem_ready=1: line_valid_set=1 in the same cycle; counter wraps to 0; next state DONE.
- DONE (1 cycle): done=1; next state IDLE. Minimum access latency: hit path req -> done = 3 cycles.
- Miss latency: 3 + N_fill cycles, plus N_wb if a write-back occurs. N_x = number of cycles in that phase, at least 2**OFFSET_W; stalls on mem_ready=0 add cycles.
- Counters saturate at 2**CNT_W-1 and never wrap.
- mem_ready outside WB/FILL: ignored.
- hit/dirty outside LOOKUP: ignored.
- Reset mid-WB/FILL: abandon the transfer; no further mem_* or cache_write; line_valid_set is not asserted.

Test Plan:
- OFFSET_W=2: rst pulse mid-cycle -> all outputs 0, busy=0 immediately (async), counters 0.
- req=1 with hit=1 in LOOKUP -> cache_hit pulse in cycle 2, done in cycle 3, hit_cnt=1, no mem_rd/mem_wr.
- Clean miss, mem_ready tied 1 -> FILL 4 cycles, offsets 0,1,2,3 with cache_write each, line_valid_set only at offset 3, done next cycle, miss_cnt=1.
- Dirty miss, WRITE_BACK=1, mem_ready low every other cycle -> mem_wr offsets 0..3 each held until ready, then mem_rd offsets 0..3, done after 8 ready cycles plus stalls.
- Same dirty miss with WRITE_BACK=0 -> no WB phase, direct FILL.
- CNT_W=2: 5 hits -> hit_cnt saturates at 3; rst asserted during FILL offset 2 -> IDLE, no line_valid_set; req in FILL ignored.
